cordic_ci_driver: RTL

- Hardware initiator for the Nios II custom-instruction (CI) handshake, driving our CORDIC CI slave so fabric logic can compute sin/cos without the CPU.
- Accepts an angle on a valid/ready command port and issues three CI transactions: rotate (n=0), read X (n=1), read Y (n=2).
- Returns the (cos, sin) pair on a valid/ready response port.
- Includes a timeout and slave-recovery path so a hung slave cannot stall the fabric.

---
 rtl/cordic_ci_pkg.sv | 23 ++
 rtl/ci_timeout_ctr.sv | 35 +++
 rtl/cordic_ci_driver.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cordic_ci_pkg.sv
// Shared opcodes, Q4.28 constants and FSM encoding for the CORDIC custom-instruction driver.
package cordic_ci_pkg;

  localparam logic [7:0] CI_OP_ROT = 8'd0;
  localparam logic [7:0] CI_OP_RDX = 8'd1;
  localparam logic [7:0] CI_OP_RDY = 8'd2;

  localparam logic signed [31:0] ONE_Q28      = 32'sd268435456;
  localparam logic signed [31:0] CORDIC_K_Q28 = 32'sd163008218;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ROT_ISSUE,
    S_ROT_WAIT,
    S_RDX_ISSUE,
    S_RDX_WAIT,
    S_RDY_ISSUE,
    S_RDY_WAIT,
    S_RESP,
    S_RECOVER
  } state_e;

endpackage

// File: rtl/ci_timeout_ctr.sv
// Wait-state counter for one CI transaction; expire_o marks the last wait cycle allowed.
module ci_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);
  localparam int unsigned   CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LAST);

endmodule

// File: rtl/cordic_ci_driver.sv
// Nios II CI initiator: rotate, read X, read Y on the CORDIC slave, with timeout recovery.
// Defining CORDIC_DRV_LATENCY_EN adds rsp_lat, the rotation latency of the answered command.
module cordic_ci_driver
  import cordic_ci_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned DATA_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_angle,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_cos,
  output logic [DATA_W-1:0] rsp_sin,
  output logic              rsp_err,
`ifdef CORDIC_DRV_LATENCY_EN
  output logic [15:0]       rsp_lat,
`endif
  output logic              ci_clk_en,
  output logic              ci_reset,
  output logic              ci_start,
  output logic [7:0]        ci_n,
  output logic [DATA_W-1:0] ci_dataa,
  output logic [DATA_W-1:0] ci_datab,
  input  logic              ci_done,
  input  logic [DATA_W-1:0] ci_result
);
  // state     | meaning
  // IDLE      | ready for a command
  // ROT_ISSUE | start pulse, rotate latched angle
  // ROT_WAIT  | wait for rotation done, result discarded
  // RDX_ISSUE | start pulse, read X (cos)
  // RDX_WAIT  | wait, capture cos
  // RDY_ISSUE | start pulse, read Y (sin)
  // RDY_WAIT  | wait, capture sin
  // RESP      | hold response until consumer takes it
  // RECOVER   | one-cycle slave reset after timeout, error response

  state_e            state_q, state_d;
  logic [DATA_W-1:0] angle_q, angle_d;
  logic [DATA_W-1:0] cos_q, cos_d;
  logic [DATA_W-1:0] sin_q, sin_d;
  logic              err_q, err_d;
  logic              tmo_clr, tmo_inc, tmo_expire, recover;
`ifdef CORDIC_DRV_LATENCY_EN
  logic [15:0]       lat_q, lat_d;
`endif

  ci_timeout_ctr #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_tmo (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (tmo_clr),
    .inc_i    (tmo_inc),
    .expire_o (tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    cos_d     = cos_q;
    sin_d     = sin_q;
    err_d     = err_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    ci_start  = 1'b0;
    ci_n      = CI_OP_ROT;
    tmo_clr   = 1'b0;
    tmo_inc   = 1'b0;
    recover   = 1'b0;
`ifdef CORDIC_DRV_LATENCY_EN
    lat_d     = lat_q;
`endif
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          angle_d = cmd_angle;
          err_d   = 1'b0;
          state_d = S_ROT_ISSUE;
        end
      end
      S_ROT_ISSUE: begin
        ci_start = 1'b1;
        tmo_clr  = 1'b1;
        state_d  = S_ROT_WAIT;
`ifdef CORDIC_DRV_LATENCY_EN
        lat_d    = 16'd1;
`endif
      end
      S_ROT_WAIT: begin
        if (ci_done) begin
          state_d = S_RDX_ISSUE;
        end else if (tmo_expire) begin
          state_d = S_RECOVER;
        end else begin
          tmo_inc = 1'b1;
`ifdef CORDIC_DRV_LATENCY_EN
          if (lat_q != 16'hFFFF) lat_d = lat_q + 16'd1;
`endif
        end
      end
      S_RDX_ISSUE: begin
        ci_start = 1'b1;
        ci_n     = CI_OP_RDX;
        tmo_clr  = 1'b1;
        state_d  = S_RDX_WAIT;
      end
      S_RDX_WAIT: begin
        ci_n = CI_OP_RDX;
        if (ci_done) begin
          cos_d   = ci_result;
          state_d = S_RDY_ISSUE;
        end else if (tmo_expire) begin
          state_d = S_RECOVER;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_RDY_ISSUE: begin
        ci_start = 1'b1;
        ci_n     = CI_OP_RDY;
        tmo_clr  = 1'b1;
        state_d  = S_RDY_WAIT;
      end
      S_RDY_WAIT: begin
        ci_n = CI_OP_RDY;
        if (ci_done) begin
          sin_d   = ci_result;
          state_d = S_RESP;
        end else if (tmo_expire) begin
          state_d = S_RECOVER;
        end else begin
          tmo_inc = 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = S_IDLE;
      end
      S_RECOVER: begin
        recover = 1'b1;
        cos_d   = '0;
        sin_d   = '0;
        err_d   = 1'b1;
        state_d = S_RESP;
`ifdef CORDIC_DRV_LATENCY_EN
        lat_d   = 16'd0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
      err_q   <= err_d;
    end
  end

`ifdef CORDIC_DRV_LATENCY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q <= '0;
    end else begin
      lat_q <= lat_d;
    end
  end
  assign rsp_lat = lat_q;
`endif

  // The operand bus only carries the angle while a command is in flight.
  assign ci_dataa  = (state_q == S_IDLE) ? '0 : angle_q;
  assign ci_datab  = '0;
  assign ci_reset  = reset | recover;
  assign ci_clk_en = ~reset;
  assign rsp_cos   = cos_q;
  assign rsp_sin   = sin_q;
  assign rsp_err   = err_q;

endmodule
